clap_detector: RTL and testbench

//  Turns a stream of signed audio samples into the clap_set level consumed by logic_controller.

---
 rtl/clap_detector.sv | 158 +++++++++++++++
 tb/tb_clap_detector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clap_detector.sv
// clap_detector: magnitude-thresholds signed audio samples and recognises a
// double clap (two hits separated by a bounded gap, with hold-off after each
// clap). A recognised double clap drives clap_set_o high for PULSE_LEN clocks.
module clap_detector #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned HOLDOFF   = 1000,
    parameter int unsigned GAP_MIN   = 2000,
    parameter int unsigned GAP_MAX   = 16000,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_vld_i,
    input  logic [DATA_W-2:0] thresh_i,
    output logic              clap_set_o,
    output logic [DATA_W-2:0] level_o,
    output logic [2:0]        state_o
);

    localparam int unsigned MAG_W = DATA_W - 1;

    localparam logic [CNT_W-1:0] C_HOLDOFF    = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] C_GAP_MIN    = CNT_W'(GAP_MIN);
    localparam logic [CNT_W-1:0] C_GAP_MAX    = CNT_W'(GAP_MAX);
    localparam logic [CNT_W-1:0] C_GAP_END    = CNT_W'(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD1 = 3'd1,
        S_WAIT2 = 3'd2,
        S_FIRE  = 3'd3,
        S_COOL  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_gap;
    logic [MAG_W-1:0]   r_level;
    logic               r_hit;
    logic               r_vld;
    logic               r_clap;
    logic [MAG_W-1:0]   w_neg;
    logic               w_is_min;
    logic [MAG_W-1:0]   w_mag;

    // Magnitude of the incoming sample; the most negative code saturates.
    assign w_neg    = MAG_W'(~sample_i[DATA_W-2:0]) + MAG_W'(1);
    assign w_is_min = (sample_i == {1'b1, {(DATA_W-1){1'b0}}});

    always_comb begin
        w_mag = sample_i[DATA_W-2:0];
        if (sample_i[DATA_W-1]) begin
            w_mag = w_is_min ? {MAG_W{1'b1}} : w_neg;
        end
    end

    // Stage 1: register magnitude, threshold decision and sample-valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_level <= '0;
            r_hit   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= sample_vld_i;
            if (sample_vld_i) begin
                r_level <= w_mag;
                r_hit   <= (w_mag >= thresh_i);
            end
        end
    end

    // Gap of the sample currently in stage 1, saturating at counter full scale.
    assign w_gap = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Stage 2 state register; clap_set_o mirrors the registered FIRE state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_clap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clap  <= (w_state_nxt == S_FIRE);
        end
    end

    // Stage 2 next-state: sample-paced except FIRE, which counts clocks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_vld && r_hit) begin
                    w_state_nxt = S_HOLD1;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD1: begin
                if (r_vld) begin
                    w_cnt_nxt = w_gap;
                    if (w_gap == C_HOLDOFF) begin
                        w_state_nxt = S_WAIT2;
                    end
                end
            end
            S_WAIT2: begin
                if (r_vld) begin
                    w_cnt_nxt = w_gap;
                    if (r_hit && (w_gap >= C_GAP_MIN) && (w_gap <= C_GAP_MAX)) begin
                        w_state_nxt = S_FIRE;
                        w_cnt_nxt   = '0;
                    end else if (r_hit) begin
                        // Too early or exactly at timeout: treat as a fresh first clap.
                        w_state_nxt = S_HOLD1;
                        w_cnt_nxt   = '0;
                    end else if (w_gap >= C_GAP_END) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_FIRE: begin
                if (r_cnt >= C_PULSE_LAST) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_COOL: begin
                if (r_vld) begin
                    if (w_gap >= C_HOLDOFF) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_gap;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign clap_set_o = r_clap;
    assign level_o    = r_level;
    assign state_o    = r_state;

endmodule

// File: tb/tb_clap_detector.sv
// tb_clap_detector: directed vectors with hand-computed expectations for
// clap_detector (DATA_W=12 HOLDOFF=4 GAP_MIN=8 GAP_MAX=20 PULSE_LEN=3).
module tb_clap_detector;

    logic        clk_i;
    logic        rst_i;
    logic [11:0] sample_i;
    logic        sample_vld_i;
    logic [10:0] thresh_i;
    logic        clap_set_o;
    logic [10:0] level_o;
    logic [2:0]  state_o;

    int n_total;
    int n_bad;

    clap_detector #(
        .DATA_W    (12),
        .HOLDOFF   (4),
        .GAP_MIN   (8),
        .GAP_MAX   (20),
        .PULSE_LEN (3),
        .CNT_W     (16)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .thresh_i     (thresh_i),
        .clap_set_o   (clap_set_o),
        .level_o      (level_o),
        .state_o      (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one clock of stimulus, then sample 1 time unit after the edge.
    task automatic step(input int s, input logic v);
        sample_i     = 12'(s);
        sample_vld_i = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        step(0, 1'b0);
        step(0, 1'b0);
        rst_i = 1'b1;
    endtask

    // First clap at sample 0, optional second clap at sample g; stops after
    // sample g+1 so outputs reflect the FSM having processed sample g.
    task automatic pair(input int g, input logic hit);
        do_reset();
        for (int k = 0; k <= g + 1; k++) begin
            step((k == 0) ? 1500 : ((k == g && hit) ? -1200 : 0), 1'b1);
        end
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst_i        = 1'b1;
        sample_i     = '0;
        sample_vld_i = 1'b0;
        thresh_i     = 11'd1000;

        // Reset with random valid samples applied.
        rst_i = 1'b0;
        step(int'($urandom_range(0, 4095)), 1'b1);
        step(int'($urandom_range(0, 4095)), 1'b1);
        check("rst_clap", 32'(clap_set_o), 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_level", 32'(level_o), 0);
        rst_i = 1'b1;

        // Basic double clap, gap 10: pulse of 3 clocks, then 4 COOL samples.
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            step((k == 0) ? 1500 : ((k == 10) ? -1200 : 0), 1'b1);
            if (k == 1)  check("t2_hold1", 32'(state_o), 1);
            if (k == 5)  check("t2_wait2", 32'(state_o), 2);
            if (k == 10) check("t2_level", 32'(level_o), 1200);
            if (k == 10 || k == 14) check("t2_low", 32'(clap_set_o), 0);
            if (k >= 11 && k <= 13) check("t2_pulse", 32'(clap_set_o), 1);
            if (k == 14 || k == 17) check("t2_cool", 32'(state_o), 4);
            if (k == 18) check("t2_idle", 32'(state_o), 0);
        end

        // Gap window edges.
        pair(8, 1'b1);
        check("g8_state", 32'(state_o), 3);
        check("g8_clap", 32'(clap_set_o), 1);
        pair(20, 1'b1);
        check("g20_state", 32'(state_o), 3);
        check("g20_clap", 32'(clap_set_o), 1);
        pair(7, 1'b1);
        check("g7_state", 32'(state_o), 1);
        check("g7_clap", 32'(clap_set_o), 0);
        for (int k = 9; k <= 16; k++) begin
            step((k == 15) ? -1200 : 0, 1'b1);
        end
        check("g7_restart_fire", 32'(state_o), 3);
        pair(21, 1'b1);
        check("g21_hit_clap", 32'(clap_set_o), 0);
        check("g21_hit_state", 32'(state_o), 1);
        pair(21, 1'b0);
        check("g21_timeout_state", 32'(state_o), 0);
        check("g21_timeout_clap", 32'(clap_set_o), 0);

        // Hits during hold-off are ignored.
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            step((k == 0) ? 1500 : ((k <= 4 || k == 9) ? 1100 : 0), 1'b1);
            if (k >= 2 && k <= 4) check("t4_hold", 32'(state_o), 1);
            if (k == 5 || k == 9) check("t4_wait", 32'(state_o), 2);
            if (k == 10) check("t4_fire", 32'(state_o), 3);
        end

        // Threshold and magnitude boundaries.
        thresh_i = 11'd2047;
        do_reset();
        step(-2048, 1'b1);
        check("min_level", 32'(level_o), 2047);
        step(0, 1'b1);
        check("min_hit", 32'(state_o), 1);
        do_reset();
        step(2047, 1'b1);
        check("max_level", 32'(level_o), 2047);
        step(0, 1'b1);
        check("max_hit", 32'(state_o), 1);
        do_reset();
        step(2046, 1'b1);
        check("below_level", 32'(level_o), 2046);
        step(0, 1'b1);
        check("below_nohit", 32'(state_o), 0);
        thresh_i = 11'd0;
        do_reset();
        step(0, 1'b1);
        step(0, 1'b1);
        check("zero_thresh_hit", 32'(state_o), 1);
        thresh_i = 11'd1000;

        // Sparse valids: gap measured in samples; reset during FIRE.
        do_reset();
        for (int s = 0; s <= 10; s++) begin
            step((s == 0) ? 1500 : ((s == 10) ? -1200 : 0), 1'b1);
            if (s < 10) begin
                step(0, 1'b0);
                step(0, 1'b0);
            end
            if (s == 9) check("sparse_wait", 32'(state_o), 2);
        end
        step(0, 1'b0);
        check("sparse_fire_state", 32'(state_o), 3);
        check("sparse_fire_clap", 32'(clap_set_o), 1);
        rst_i = 1'b0;
        step(0, 1'b0);
        check("fire_rst_clap", 32'(clap_set_o), 0);
        check("fire_rst_state", 32'(state_o), 0);
        rst_i = 1'b1;
        step(0, 1'b0);
        check("fire_rst_no_resume", 32'(clap_set_o), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
